// File: rtl/rv32i_instr_encoder.sv
// RV32I instruction encoder: packs decoded fields into 32-bit words and streams them into imem.
// Optional build macro NOP_PAD_EN: on flush, pad the remaining memory with addi x0,x0,0 before closing.
module rv32i_instr_encoder #(
  parameter int                ADDR_W    = 10,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        in_opcode,
  input  logic [2:0]        in_funct3,
  input  logic              in_funct7,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  input  logic              flush,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   word_count,
  output logic              full,
  output logic              err,
  output logic              done
);

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, WRITE, PAD, DONE} state_t;

  state_t          state_q;
  logic            we_q;
  logic [31:0]     wdata_q;
  logic [ADDR_W:0] count_q;
  logic            err_q;
  logic            done_q;
  logic            pend_q;

  logic [31:0]     wdata_d;
  logic            known_d;
  logic            misalign_d;
  logic            flush_go;

  function automatic logic is_known(input logic [6:0] op);
    case (op)
      7'd3, 7'd103, 7'd19, 7'd35, 7'd51, 7'd23, 7'd55, 7'd99, 7'd111: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] encode(
    input logic [6:0]  op,
    input logic [2:0]  f3,
    input logic        f7,
    input logic [4:0]  rd,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [31:0] imm
  );
    logic [11:0] imm_i;
    logic [2:0]  f3_i;
    imm_i  = imm[11:0];
    f3_i   = f3;
    encode = '0;
    case (op)
      7'd3, 7'd103, 7'd19: begin
        if (op == 7'd103) f3_i = 3'b000;
        // Shift-immediates carry the SRAI select in the upper immediate bits
        if (op == 7'd19 && (f3 == 3'b001 || f3 == 3'b101)) imm_i[11:5] = {1'b0, f7, 5'b0};
        encode = {imm_i, rs1, f3_i, rd, op};
      end
      7'd35:        encode = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
      7'd51:        encode = {1'b0, f7, 5'b0, rs2, rs1, f3, rd, op};
      7'd23, 7'd55: encode = {imm[31:12], rd, op};
      7'd99:        encode = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
      7'd111:       encode = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
      default:      encode = '0;
    endcase
  endfunction

  assign wdata_d    = encode(in_opcode, in_funct3, in_funct7, in_rd, in_rs1, in_rs2, in_imm);
  assign known_d    = is_known(in_opcode);
  assign misalign_d = in_imm[0] & (in_opcode == 7'd99 || in_opcode == 7'd111);
  assign flush_go   = flush | pend_q;

  assign full       = count_q[ADDR_W];
  assign in_ready   = (state_q == IDLE) & ~full & ~done_q & ~flush & ~pend_q & ~reset;

  assign imem_we    = we_q;
  assign imem_addr  = BASE_ADDR + count_q[ADDR_W-1:0];
  assign imem_wdata = wdata_q;
  assign word_count = count_q;
  assign err        = err_q;
  assign done       = done_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      wdata_q <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (flush_go) begin
            pend_q <= 1'b0;
`ifdef NOP_PAD_EN
            if (full) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= PAD;
              we_q    <= 1'b1;
              wdata_q <= NOP_WORD;
            end
`else
            state_q <= DONE;
            done_q  <= 1'b1;
`endif
          end else if (in_valid && in_ready) begin
            // Unknown opcodes complete the handshake but never reach memory
            if (!known_d) begin
              err_q <= 1'b1;
            end else begin
              state_q <= WRITE;
              we_q    <= 1'b1;
              wdata_q <= wdata_d;
              if (misalign_d) err_q <= 1'b1;
            end
          end
        end
        WRITE: begin
          we_q    <= 1'b0;
          count_q <= count_q + (ADDR_W+1)'(1);
          state_q <= IDLE;
          if (flush) pend_q <= 1'b1;
        end
        PAD: begin
          count_q <= count_q + (ADDR_W+1)'(1);
          if (&count_q[ADDR_W-1:0]) begin
            state_q <= DONE;
            we_q    <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          we_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32i_instr_encoder.sv
// Randomized bench for rv32i_instr_encoder against a transaction-level encoder/memory model.
// Expectations for flush follow the NOP_PAD_EN build macro.
module tb_rv32i_instr_encoder;

  localparam int ADDR_W = 3;
  localparam int CAP    = 8;
  localparam int BASE   = 6;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [6:0]        in_opcode = '0;
  logic [2:0]        in_funct3 = '0;
  logic              in_funct7 = 1'b0;
  logic [4:0]        in_rd = '0;
  logic [4:0]        in_rs1 = '0;
  logic [4:0]        in_rs2 = '0;
  logic [31:0]       in_imm = '0;
  logic              flush = 1'b0;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic [ADDR_W:0]   word_count;
  logic              full;
  logic              err;
  logic              done;

  int n_chk  = 0;
  int n_fail = 0;

  int m_cnt  = 0;
  bit m_err  = 1'b0;
  bit m_done = 1'b0;

  logic [6:0] known_ops [9] = '{7'd3, 7'd103, 7'd19, 7'd35, 7'd51, 7'd23, 7'd55, 7'd99, 7'd111};
  logic [6:0] bad_ops   [4] = '{7'h7F, 7'h0F, 7'h73, 7'h0B};

  rv32i_instr_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(3'd6)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .flush(flush), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .word_count(word_count), .full(full), .err(err), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic bit is_known_m(input logic [6:0] op);
    foreach (known_ops[i]) if (known_ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  // Field placement from the RV32I format tables, built with shifts and masks
  function automatic logic [31:0] ref_enc(input logic [31:0] op, input logic [31:0] f3,
                                          input logic [31:0] f7, input logic [31:0] rd,
                                          input logic [31:0] rs1, input logic [31:0] rs2,
                                          input logic [31:0] imm);
    logic [31:0] ii;
    case (op)
      32'd3, 32'd19, 32'd103: begin
        ii = imm & 32'hFFF;
        if (op == 32'd19 && (f3 == 32'd1 || f3 == 32'd5)) ii = (f7 << 10) | (imm & 32'd31);
        return (ii << 20) | (rs1 << 15) | ((op == 32'd103 ? 32'd0 : f3) << 12) | (rd << 7) | op;
      end
      32'd35: return (((imm >> 5) & 32'd127) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
                     | ((imm & 32'd31) << 7) | op;
      32'd51: return (f7 << 30) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
      32'd23, 32'd55: return (imm & 32'hFFFF_F000) | (rd << 7) | op;
      32'd99: return (((imm >> 12) & 32'd1) << 31) | (((imm >> 5) & 32'd63) << 25) | (rs2 << 20)
                     | (rs1 << 15) | (f3 << 12) | (((imm >> 1) & 32'd15) << 8)
                     | (((imm >> 11) & 32'd1) << 7) | op;
      32'd111: return (((imm >> 20) & 32'd1) << 31) | (((imm >> 1) & 32'd1023) << 21)
                      | (((imm >> 11) & 32'd1) << 20) | (((imm >> 12) & 32'd255) << 12)
                      | (rd << 7) | op;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] exp_addr(input int cnt);
    return 32'((BASE + cnt) % CAP);
  endfunction

  task automatic chk_status(input string tag);
    chk({tag, "_count"}, 32'(word_count), 32'(m_cnt));
    chk({tag, "_full"},  32'(full),       32'(m_cnt == CAP));
    chk({tag, "_err"},   32'(err),        32'(m_err));
    chk({tag, "_done"},  32'(done),       32'(m_done));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_we",    32'(imem_we),  32'd0);
    chk("rst_addr",  32'(imem_addr), exp_addr(0));
    chk("rst_wdata", imem_wdata, 32'd0);
    m_cnt = 0; m_err = 1'b0; m_done = 1'b0;
    chk_status("rst");
    reset = 1'b0;
  endtask

  // want != 0 pins the expected word to a literal instead of the model
  task automatic send(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [31:0] imm, input logic [31:0] want, input bit pf);
    bit acc, kn;
    logic [31:0] w;
    kn = is_known_m(op);
    @(negedge clk);
    in_opcode = op; in_funct3 = f3; in_funct7 = f7;
    in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_valid = 1'b1;
    #1;
    acc = (m_cnt < CAP) && !m_done;
    chk("in_ready", 32'(in_ready), 32'(acc));
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    if (acc && kn) begin
      w = (want != 32'd0) ? want
          : ref_enc(32'(op), 32'(f3), 32'(f7), 32'(rd), 32'(rs1), 32'(rs2), imm);
      chk("wr_we",    32'(imem_we), 32'd1);
      chk("wr_addr",  32'(imem_addr), exp_addr(m_cnt));
      chk("wr_wdata", imem_wdata, w);
      if ((op == 7'd99 || op == 7'd111) && imm[0]) m_err = 1'b1;
      m_cnt++;
      if (pf) begin
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
      end
      @(negedge clk);
      chk("wr_we_off", 32'(imem_we), 32'd0);
      chk("ready_after", 32'(in_ready), 32'(!pf && m_cnt < CAP && !m_done));
    end else begin
      chk("no_we", 32'(imem_we), 32'd0);
      if (acc) m_err = 1'b1;
    end
    chk_status("send");
  endtask

  task automatic post_flush();
    if (!m_done) begin
`ifdef NOP_PAD_EN
      while (m_cnt < CAP) begin
        @(negedge clk);
        chk("pad_we",    32'(imem_we), 32'd1);
        chk("pad_addr",  32'(imem_addr), exp_addr(m_cnt));
        chk("pad_wdata", imem_wdata, 32'h0000_0013);
        chk("pad_count", 32'(word_count), 32'(m_cnt));
        m_cnt++;
      end
`endif
      m_done = 1'b1;
    end
    @(negedge clk);
    chk("fl_we", 32'(imem_we), 32'd0);
    chk_status("fl");
    repeat (2) begin
      @(negedge clk);
      chk("dn_we",    32'(imem_we),  32'd0);
      chk("dn_ready", 32'(in_ready), 32'd0);
    end
  endtask

  task automatic do_flush(input bit with_valid);
    @(negedge clk);
    in_opcode = 7'd19; in_funct3 = 3'd0; in_rd = 5'd1; in_imm = 32'd1;
    flush = 1'b1; in_valid = with_valid;
    #1;
    chk("flush_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1 flush = 1'b0; in_valid = 1'b0;
    post_flush();
  endtask

  task automatic rand_bundle();
    logic [6:0] op;
    logic [31:0] imm;
    int k;
    k = $urandom_range(0, 10);
    op = (k < 9) ? known_ops[k] : bad_ops[$urandom_range(0, 3)];
    imm = $urandom;
    if ((op == 7'd99 || op == 7'd111) && $urandom_range(0, 3) != 0) imm[0] = 1'b0;
    send(op, 3'($urandom), 1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
         imm, 32'd0, 1'b0);
  endtask

  initial begin
    do_reset();
    send(7'd19, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5,          32'h0050_0093, 1'b0);
    send(7'd51, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0,          32'h4020_81B3, 1'b0);
    send(7'd99, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8,          32'h0020_8463, 1'b0);
    chk("beq8_err", 32'(err), 32'd0);
    send(7'd99, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd9,          32'h0020_8463, 1'b0);
    send(7'd55, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h1234_5000,  32'h1234_52B7, 1'b0);
    send(7'h7F, 3'd0, 1'b0, 5'd1, 5'd1, 5'd1, 32'd0,          32'd0,         1'b0);
    send(7'd19, 3'd5, 1'b1, 5'd1, 5'd2, 5'd0, 32'd3,          32'h4031_5093, 1'b0);
    do_flush(1'b1);
    send(7'd19, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 32'd0, 1'b0);

    // Reset landing in the middle of a write
    @(negedge clk);
    in_opcode = 7'd19; in_funct3 = 3'd0; in_rd = 5'd2; in_imm = 32'd7; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    do_reset();

    for (int r = 0; r < 8; r++) begin
      int n;
      do_reset();
      n = $urandom_range(1, 11);
      for (int i = 0; i < n; i++) rand_bundle();
      if (r == 2 && m_cnt < CAP) begin
        send(7'd19, 3'd0, 1'b0, 5'd4, 5'd4, 5'd0, 32'd1, 32'd0, 1'b1);
        post_flush();
      end else begin
        do_flush(1'($urandom));
      end
      rand_bundle();
      do_flush(1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
